// File: rtl/sauria_cfg_addr_router.sv
// sauria_cfg_addr_router
//   Routes single outstanding configuration requests from one upstream
//   port to one of N_TARGETS address regions. A region hits when
//   (addr & TGT_MASK[i]) == TGT_BASE[i]; the lowest hitting index wins.
//   Unmapped requests and targets that do not complete within
//   TIMEOUT_CYCLES get an error response. One transaction at a time.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_req/o_gnt            upstream handshake (accept when both high)
//   i_addr/i_we/i_wdata    upstream request payload
//   o_rvalid/o_rdata/o_err one-cycle upstream response
//   o_tgt_req              one-hot request to the selected target
//   i_tgt_gnt              per-target grant
//   o_tgt_addr/_we/_wdata  forwarded request (address is region-local)
//   i_tgt_rvalid/_rdata    per-target response, rdata slice i = target i
//   o_busy                 transaction in flight
module sauria_cfg_addr_router #(
    parameter int N_TARGETS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter logic [N_TARGETS-1:0][ADDR_W-1:0] TGT_BASE =
        {32'h000C_0000, 32'h0008_0000, 32'h0004_0000, 32'h0000_0000},
    parameter logic [N_TARGETS-1:0][ADDR_W-1:0] TGT_MASK =
        {N_TARGETS{ADDR_W'(32'h003C_0000)}},
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_req,
    output logic                          o_gnt,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          i_we,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic                          o_rvalid,
    output logic [DATA_W-1:0]             o_rdata,
    output logic                          o_err,
    output logic [N_TARGETS-1:0]          o_tgt_req,
    input  logic [N_TARGETS-1:0]          i_tgt_gnt,
    output logic [ADDR_W-1:0]             o_tgt_addr,
    output logic                          o_tgt_we,
    output logic [DATA_W-1:0]             o_tgt_wdata,
    input  logic [N_TARGETS-1:0]          i_tgt_rvalid,
    input  logic [N_TARGETS*DATA_W-1:0]   i_tgt_rdata,
    output logic                          o_busy
);

    localparam int IW = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Counter value during the last allowed FWD/WAIT cycle.
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_FWD, S_WAIT, S_RESP} state_t;

    state_t              state, state_nx;
    logic [IW-1:0]       idx;
    logic [ADDR_W-1:0]   tgt_addr;
    logic                tgt_we;
    logic [DATA_W-1:0]   tgt_wdata;
    logic [DATA_W-1:0]   rdata;
    logic                err;
    logic [CW-1:0]       cnt;

    logic                hit;
    logic [IW-1:0]       hit_idx;
    logic [ADDR_W-1:0]   hit_off;
    logic                accept;
    logic                sel_gnt, sel_rvalid;
    logic [DATA_W-1:0]   sel_rdata;
    logic                active, expired, done, timeout;

    // Lowest index wins: scan downward so the last match written is the lowest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_TARGETS - 1; i >= 0; i--) begin
            if ((i_addr & TGT_MASK[i]) == TGT_BASE[i]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign hit_off    = i_addr & ~TGT_MASK[hit_idx] & ~TGT_BASE[hit_idx];
    assign accept     = i_req && o_gnt;

    // Only the selected target's handshake is ever looked at.
    assign sel_gnt    = i_tgt_gnt[idx];
    assign sel_rvalid = i_tgt_rvalid[idx];
    assign sel_rdata  = i_tgt_rdata[idx*DATA_W +: DATA_W];

    assign active  = (state == S_FWD) || (state == S_WAIT);
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign done    = ((state == S_FWD) && sel_gnt && sel_rvalid) ||
                     ((state == S_WAIT) && sel_rvalid);
    // Completion in the same cycle as expiry still counts as success.
    assign timeout = active && expired && !done;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = hit ? S_FWD : S_RESP;
            S_FWD: begin
                if (done || expired) state_nx = S_RESP;
                else if (sel_gnt)    state_nx = S_WAIT;
            end
            S_WAIT: if (done || expired) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            tgt_addr  <= '0;
            tgt_we    <= 1'b0;
            tgt_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            state <= state_nx;
            cnt   <= active ? cnt + 1'b1 : '0;
            if (accept) begin
                idx       <= hit ? hit_idx : '0;
                tgt_addr  <= hit ? hit_off : '0;
                tgt_we    <= i_we;
                tgt_wdata <= i_wdata;
                err       <= !hit;
                rdata     <= '0;
            end
            if (done) begin
                rdata <= sel_rdata;
                err   <= 1'b0;
            end else if (timeout) begin
                err   <= 1'b1;
            end
        end
    end

    always_comb begin
        o_tgt_req = '0;
        if (state == S_FWD) o_tgt_req[idx] = 1'b1;
    end

    assign o_gnt       = (state == S_IDLE) && !i_rst;
    assign o_busy      = (state != S_IDLE);
    assign o_rvalid    = (state == S_RESP);
    assign o_err       = (state == S_RESP) && err;
    assign o_rdata     = ((state == S_RESP) && !err && !tgt_we) ? rdata : '0;
    assign o_tgt_addr  = tgt_addr;
    assign o_tgt_we    = tgt_we;
    assign o_tgt_wdata = tgt_wdata;

endmodule

// File: doc/sauria_cfg_addr_router.md
SAURIA_CFG_ADDR_ROUTER -- requirements
Module: sauria_cfg_addr_router

Interface
REQ-001 SHALL have parameter N_TARGETS, default 4, number of decoded target regions (1..16).
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TGT_BASE, an N_TARGETS x ADDR_W array, default {0x0000_0000, 0x0004_0000, 0x0008_0000, 0x000C_0000}, the region base per target.
REQ-005 SHALL have parameter TGT_MASK, an N_TARGETS x ADDR_W array, default 0x003C_0000 for every entry, the decode mask per target.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 256, the response timeout; 0 disables the timeout.
REQ-007 SHALL have ports:
- i_clk  in  1  clock; single clock domain, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  1  upstream request valid.
- o_gnt  out  1  upstream grant; a request is accepted when i_req and o_gnt are both high.
- i_addr  in  ADDR_W  upstream address.
- i_we  in  1  write enable; 1 = write, 0 = read.
- i_wdata  in  DATA_W  write data.
- o_rvalid  out  1  one-cycle response pulse.
- o_rdata  out  DATA_W  read data.
- o_err  out  1  error flag, qualified by o_rvalid.
- o_tgt_req  out  N_TARGETS  one-hot target request.
- i_tgt_gnt  in  N_TARGETS  per-target grant.
- o_tgt_addr  out  ADDR_W  local offset, equal to addr & ~TGT_MASK[idx] & ~TGT_BASE[idx].
- o_tgt_we  out  1  forwarded write enable.
- o_tgt_wdata  out  DATA_W  forwarded write data.
- i_tgt_rvalid  in  N_TARGETS  per-target response or write-acknowledge.
- i_tgt_rdata  in  N_TARGETS*DATA_W  per-target read data; target i occupies slice i.
- o_busy  out  1  high in every state except IDLE.

Function
REQ-008 SHALL decode target i as hit when (addr & TGT_MASK[i]) == TGT_BASE[i]; when more than one target hits, the lowest index wins.
REQ-009 SHALL implement four states: IDLE, FWD, WAIT, RESP.
REQ-010 SHALL drive o_gnt = 1 only in IDLE, combinationally.
REQ-011 SHALL register addr, we, wdata and the decoded index on acceptance.
REQ-012 SHALL, on acceptance, go IDLE -> FWD on a hit, or IDLE -> RESP with a pending error on a miss.
REQ-013 SHALL, in FWD, hold o_tgt_req[idx] = 1 and stable o_tgt_addr/o_tgt_we/o_tgt_wdata until i_tgt_gnt[idx] = 1, then go to WAIT.
REQ-014 SHALL, in FWD, go directly to RESP when i_tgt_gnt[idx] and i_tgt_rvalid[idx] are high in the same cycle.
REQ-015 SHALL, in WAIT, go to RESP on i_tgt_rvalid[idx], capturing i_tgt_rdata slice idx.
REQ-016 SHALL ignore i_tgt_gnt and i_tgt_rvalid from non-selected targets in every state.
REQ-017 SHALL, in RESP, assert o_rvalid for exactly one cycle, then return to IDLE.
- Success: o_err = 0; o_rdata = captured data on reads, 0 on writes.
- Error: o_err = 1 and o_rdata = 0.
REQ-018 SHALL keep o_rvalid, o_err and o_rdata at 0 outside RESP.
REQ-019 SHALL count cycles spent in FWD and WAIT with a counter of width clog2(TIMEOUT_CYCLES+1).
- When the counter reaches TIMEOUT_CYCLES without completion, drop o_tgt_req and go to RESP with o_err = 1.
REQ-020 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-021 SHALL never time out when TIMEOUT_CYCLES = 0.
REQ-022 SHALL meet these latencies:
- Unmapped request: o_rvalid one cycle after acceptance.
- Mapped request with zero-wait target (gnt in FWD, rvalid next cycle): o_rvalid three cycles after acceptance.

Reset
REQ-023 SHALL, while i_rst = 1 on a clock edge, force the following, aborting any in-flight transaction with no response generated:
- state = IDLE;
- timeout counter = 0;
- o_tgt_req = 0, o_rvalid = 0, o_err = 0, o_rdata = 0, o_busy = 0;
- o_tgt_addr = 0, o_tgt_we = 0, o_tgt_wdata = 0.
REQ-024 SHALL drive o_gnt = 0 while i_rst = 1, and o_gnt = 1 in the first cycle after reset release.

Verification
REQ-025 Read 0x0008_0010: stimulus target 2 grants immediately and returns rdata 0xA5A5_0001 the next cycle -> required response o_tgt_req = 4'b0100, o_tgt_addr = 0x10, o_rvalid with o_rdata = 0xA5A5_0001 and o_err = 0, three cycles after acceptance.
REQ-026 Read 0x0010_0000 (unmapped) -> o_tgt_req stays 0; o_rvalid with o_err = 1 and o_rdata = 0, one cycle after acceptance.
REQ-027 Write 0x0004_0004 with data 0x1234, TIMEOUT_CYCLES = 8, target 1 never grants -> o_tgt_req[1] held for 8 cycles, then o_rvalid with o_err = 1.
REQ-028 Target 3 gives gnt and rvalid in the same FWD cycle; target 0 gives a stray rvalid -> a single correct response from target 3; the stray rvalid has no effect.
REQ-029 i_rst asserted during WAIT -> next cycle IDLE with all outputs 0, no o_rvalid; a new read afterwards completes normally.
REQ-030 Overlapping TGT_BASE/TGT_MASK for targets 1 and 2 -> target 1 is selected.
